// File: rtl/shift_accumulator.sv
// Saturating dot-product accumulator for the log-quantized MAC stream.
// Sums a programmed number of signed products, then emits the raw sum and an int8 requantized activation.
module shift_accumulator #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_relu_en,
  input  logic [4:0]       i_shift,
  input  logic             i_valid,
  input  logic [31:0]      i_product,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic [7:0]       o_act,
  output logic             o_ovf,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACT_MAX = {{(ACC_W-7){1'b0}}, 7'h7f};
  localparam logic signed [ACC_W-1:0] ACT_MIN = {{(ACC_W-7){1'b1}}, 7'h00};

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0]        cnt_q;
  logic [LEN_W-1:0]        len_q;
  logic                    relu_q;
  logic [4:0]              shift_q;
  logic                    ovf_q;
  logic [7:0]              act_q;

  logic signed [ACC_W:0]   wide_d;
  logic                    ovf_hit_d;
  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] relu_d;
  logic signed [ACC_W-1:0] shifted_d;
  logic [7:0]              act_d;
  logic                    last_d;

  // One guard bit above the accumulator detects overflow; the sum then pins to the rail.
  always_comb begin
    wide_d    = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-31){i_product[31]}}, i_product};
    ovf_hit_d = wide_d[ACC_W] ^ wide_d[ACC_W-1];
    sum_d     = wide_d[ACC_W-1:0];
    if (ovf_hit_d) begin
      sum_d = wide_d[ACC_W] ? SUM_MIN : SUM_MAX;
    end
    relu_d    = (relu_q && sum_d[ACC_W-1]) ? '0 : sum_d;
    shifted_d = relu_d >>> shift_q;
    if (shifted_d > ACT_MAX) begin
      act_d = 8'h7f;
    end else if (shifted_d < ACT_MIN) begin
      act_d = 8'h80;
    end else begin
      act_d = shifted_d[7:0];
    end
    last_d = (cnt_q == len_q - LEN_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      relu_q  <= 1'b0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
      act_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            act_q   <= '0;
            len_q   <= i_len;
            relu_q  <= i_relu_en;
            shift_q <= i_shift;
            state_q <= (i_len == '0) ? OUT : ACC;
          end
        end
        ACC: begin
          if (i_valid) begin
            acc_q <= sum_d;
            cnt_q <= cnt_q + LEN_W'(1);
            if (ovf_hit_d) begin
              ovf_q <= 1'b1;
            end
            // Activation is captured with the final term so it is ready with o_valid.
            if (last_d) begin
              act_q   <= act_d;
              state_q <= OUT;
            end
          end
        end
        OUT: begin
          if (i_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == ACC);
  assign o_valid = (state_q == OUT);
  assign o_busy  = (state_q != IDLE);
  assign o_sum   = acc_q;
  assign o_act   = act_q;
  assign o_ovf   = ovf_q;

endmodule
